dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 27 ++
 rtl/dm_arbiter_arb_pick.sv | 36 +++
 rtl/dm_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DM_HIGH_EDGE : default highest legal DM byte address
//   PORT_CPU/DMA : port indices (0 = CPU MEM stage, 1 = DMA bridge)
//   state_e      : arbiter FSM encoding
//   dm_req_t     : one port's access request fields
package dm_arbiter_pkg;

  localparam logic [31:0] DM_HIGH_EDGE = 32'h0000_00FF;
  localparam int          NUM_PORTS    = 2;
  localparam logic        PORT_CPU     = 1'b0;
  localparam logic        PORT_DMA     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } dm_req_t;

endpackage

// File: rtl/dm_arbiter_arb_pick.sv
// arb_pick: combinational winner selection for the two DM requesters.
//   req  : request vector {DMA, CPU}
//   last : port granted most recently (round-robin pointer)
//   any  : at least one request present
//   win  : selected port (meaningful only when any = 1)
// Build option: DM_ARB_CPU_PRIO_EN -> CPU wins every tie, 'last' is ignored.
module arb_pick
  import dm_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic                 any,
  output logic                 win
);

`ifdef DM_ARB_CPU_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    any = |req;
    win = PORT_CPU;
    if (&req) begin
`ifdef DM_ARB_CPU_PRIO_EN
      win = PORT_CPU;
`else
      // tie: the port that was not served last goes next
      win = ~last;
`endif
    end else if (req[PORT_DMA]) begin
      win = PORT_DMA;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port (CPU / DMA) arbiter in front of a single-port
// combinational-read data memory. One access every three cycles:
// IDLE (sample) -> GNTx (drive DM) -> DONE (Ack pulse) -> IDLE.
// Ports:
//   Clock, Reset (async, active low)
//   Req/Wr/Addr/WD/BE 0|1 : requester inputs
//   Ack/Err/RD 0|1        : completion pulse, range error, load data
//   MemWrite/MemRead/DmAddr/DmWD/DmBE : DM strobes and bus, DmRD : DM data
// Build option: DM_ARB_CPU_PRIO_EN selects fixed CPU priority instead of
// round-robin; the pointer flop is then not built.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] DM_HIGH = DM_HIGH_EDGE
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WD0,
  input  logic [31:0] WD1,
  input  logic [3:0]  BE0,
  input  logic [3:0]  BE1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] RD0,
  output logic [31:0] RD1,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] DmAddr,
  output logic [31:0] DmWD,
  output logic [3:0]  DmBE,
  input  logic [31:0] DmRD
);

  state_e                            state_q, state_d;
  dm_req_t                           lat_q, lat_d;
  logic                              gnt_q, gnt_d;
  logic [NUM_PORTS-1:0][31:0]        rd_q, rd_d;
  logic [NUM_PORTS-1:0]              err_q, err_d;
  dm_req_t [NUM_PORTS-1:0]           port_req;
  logic                              pick_any, pick_win, last, oor;

  assign port_req[PORT_CPU] = '{wr: Wr0, addr: Addr0, wd: WD0, be: BE0};
  assign port_req[PORT_DMA] = '{wr: Wr1, addr: Addr1, wd: WD1, be: BE1};

  arb_pick u_pick (
    .req  ({Req1, Req0}),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

`ifndef DM_ARB_CPU_PRIO_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && pick_any) last_d = pick_win;
  end

  // reset value DMA means the CPU wins the first tie
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) last_q <= PORT_DMA;
    else        last_q <= last_d;
  end

  assign last = last_q;
`else
  assign last = PORT_DMA;
`endif

  assign oor = (lat_q.addr > DM_HIGH);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    gnt_d    = gnt_q;
    rd_d     = rd_q;
    err_d    = err_q;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    DmAddr   = '0;
    DmWD     = '0;
    DmBE     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_win;
          lat_d   = port_req[pick_win];
          state_d = pick_win ? ST_GNT1 : ST_GNT0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        DmAddr   = lat_q.addr;
        DmWD     = lat_q.wd;
        DmBE     = lat_q.be;
        // out-of-range accesses never strobe the DM
        MemWrite = lat_q.wr & ~oor;
        MemRead  = ~lat_q.wr & ~oor;
        rd_d[gnt_q]  = oor ? '0 : DmRD;
        err_d[gnt_q] = oor;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // strobes decode from state_q, so an async reset in GNTx kills MemWrite at once
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      gnt_q   <= PORT_CPU;
      rd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign Ack0 = (state_q == ST_DONE) && (gnt_q == PORT_CPU);
  assign Ack1 = (state_q == ST_DONE) && (gnt_q == PORT_DMA);
  assign Err0 = err_q[PORT_CPU];
  assign Err1 = err_q[PORT_DMA];
  assign RD0  = rd_q[PORT_CPU];
  assign RD1  = rd_q[PORT_DMA];

endmodule
